// File: rtl/frac_search_sad_pkg.sv
// Shared definitions for the fractional-pel SAD search engine: default
// geometry, FSM state encoding and a constant-evaluable clog2.
package frac_search_sad_pkg;

    localparam int PIX_W_DEF    = 8;
    localparam int ROW_PIX_DEF  = 8;
    localparam int NUM_CAND_DEF = 9;
    localparam int BLK_ROWS_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/frac_search_sad_sad_row.sv
// One candidate's row SAD: ROW_PIX absolute differences summed and
// registered as the first pipeline stage.
module sad_row
    import frac_search_sad_pkg::*;
#(
    parameter int PIX_W   = PIX_W_DEF,
    parameter int ROW_PIX = ROW_PIX_DEF,
    localparam int SUM_W  = PIX_W + clog2(ROW_PIX)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic [ROW_PIX*PIX_W-1:0] ref_pix,
    input  logic [ROW_PIX*PIX_W-1:0] cand_pix,
    output logic [SUM_W-1:0]         row_sum
);

    logic [SUM_W-1:0] sum_s;
    logic [SUM_W-1:0] row_sum_r;

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                   input logic [PIX_W-1:0] b);
        if (a >= b) begin
            abs_diff = a - b;
        end else begin
            abs_diff = b - a;
        end
    endfunction

    // Sum of per-pixel absolute differences across the row beat
    always_comb begin
        sum_s = {SUM_W{1'b0}};
        for (int p = 0; p < ROW_PIX; p++) begin
            sum_s = sum_s + SUM_W'(abs_diff(ref_pix[p*PIX_W +: PIX_W],
                                            cand_pix[p*PIX_W +: PIX_W]));
        end
    end

    // Stage-1 register, loaded on every accepted beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_sum_r <= {SUM_W{1'b0}};
        end else if (clr) begin
            row_sum_r <= {SUM_W{1'b0}};
        end else if (en) begin
            row_sum_r <= sum_s;
        end
    end

    assign row_sum = row_sum_r;

endmodule

// File: rtl/frac_search_sad.sv
// Fractional-pel search: accumulates one SAD per sub-pel candidate over a
// block, then scans for the lowest eligible SAD (ties keep the lower index).
module frac_search_sad
    import frac_search_sad_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int ROW_PIX  = ROW_PIX_DEF,
    parameter int NUM_CAND = NUM_CAND_DEF,
    parameter int BLK_ROWS = BLK_ROWS_DEF,
    localparam int SAD_W   = PIX_W + clog2(ROW_PIX*BLK_ROWS),
    localparam int IDX_W   = clog2(NUM_CAND)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_CAND-1:0]               cand_mask,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ROW_PIX*PIX_W-1:0]          ref_pix,
    input  logic [NUM_CAND*ROW_PIX*PIX_W-1:0] cand_pix,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [IDX_W-1:0]                  best_idx,
    output logic [SAD_W-1:0]                  best_sad
);

    localparam int SUM_W = PIX_W + clog2(ROW_PIX);
    localparam int RC_W  = (clog2(BLK_ROWS) > 0) ? clog2(BLK_ROWS) : 1;
    localparam logic [RC_W-1:0]  LAST_ROW = RC_W'(BLK_ROWS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    state_e               state_r;
    state_e               state_next_s;
    logic [RC_W-1:0]      row_cnt_r;
    logic [NUM_CAND-1:0]  mask_r;
    logic                 stage1_vld_r;
    logic [SAD_W-1:0]     acc_r [NUM_CAND];
    logic [SUM_W-1:0]     row_sum_s [NUM_CAND];
    logic [IDX_W-1:0]     scan_idx_r;
    logic [SAD_W-1:0]     run_sad_r;
    logic [IDX_W-1:0]     run_idx_r;
    logic [SAD_W-1:0]     next_sad_s;
    logic [IDX_W-1:0]     next_idx_s;
    logic                 better_s;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [IDX_W-1:0]     best_idx_r;
    logic [SAD_W-1:0]     best_sad_r;
    logic                 start_acc_s;
    logic                 accept_s;

    assign start_acc_s = (state_r == ST_IDLE) && start;
    assign accept_s    = (state_r == ST_ACCUM) && in_valid;

    for (genvar k = 0; k < NUM_CAND; k++) begin : g_row
        sad_row #(
            .PIX_W   (PIX_W),
            .ROW_PIX (ROW_PIX)
        ) u_row (
            .clk      (clk),
            .reset    (reset),
            .clr      (start_acc_s),
            .en       (accept_s),
            .ref_pix  (ref_pix),
            .cand_pix (cand_pix[k*ROW_PIX*PIX_W +: ROW_PIX*PIX_W]),
            .row_sum  (row_sum_s[k])
        );
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s && (row_cnt_r == LAST_ROW)) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_DRAIN: state_next_s = ST_SCAN;
            ST_SCAN: begin
                if (scan_idx_r == LAST_IDX) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SCAN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Scan comparator: strict less-than so an equal later SAD never displaces
    always_comb begin
        better_s   = mask_r[scan_idx_r] && (acc_r[scan_idx_r] < run_sad_r);
        next_sad_s = run_sad_r;
        next_idx_s = run_idx_r;
        if (better_s) begin
            next_sad_s = acc_r[scan_idx_r];
            next_idx_s = scan_idx_r;
        end else begin
            next_sad_s = run_sad_r;
            next_idx_s = run_idx_r;
        end
    end

    // Row counter, mask latch and stage-1 valid tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_cnt_r    <= {RC_W{1'b0}};
            mask_r       <= {NUM_CAND{1'b0}};
            stage1_vld_r <= 1'b0;
        end else begin
            stage1_vld_r <= accept_s;
            if (start_acc_s) begin
                row_cnt_r <= {RC_W{1'b0}};
                mask_r    <= cand_mask;
            end else if (accept_s) begin
                row_cnt_r <= row_cnt_r + RC_W'(1'b1);
            end
        end
    end

    // Accumulators add the previous beat's registered row sums
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CAND; k++) begin
                acc_r[k] <= {SAD_W{1'b0}};
            end
        end else if (start_acc_s) begin
            for (int k = 0; k < NUM_CAND; k++) begin
                acc_r[k] <= {SAD_W{1'b0}};
            end
        end else if (stage1_vld_r) begin
            for (int k = 0; k < NUM_CAND; k++) begin
                acc_r[k] <= acc_r[k] + SAD_W'(row_sum_s[k]);
            end
        end
    end

    // Scan index and running best
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_idx_r <= {IDX_W{1'b0}};
            run_sad_r  <= {SAD_W{1'b1}};
            run_idx_r  <= {IDX_W{1'b0}};
        end else if (state_r == ST_DRAIN) begin
            scan_idx_r <= {IDX_W{1'b0}};
            run_sad_r  <= {SAD_W{1'b1}};
            run_idx_r  <= {IDX_W{1'b0}};
        end else if ((state_r == ST_SCAN) && (scan_idx_r != LAST_IDX)) begin
            scan_idx_r <= scan_idx_r + IDX_W'(1'b1);
            run_sad_r  <= next_sad_s;
            run_idx_r  <= next_idx_s;
        end
    end

    // Registered handshake flags and result, loaded on the final scan step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            best_idx_r  <= {IDX_W{1'b0}};
            best_sad_r  <= {SAD_W{1'b0}};
        end else begin
            in_ready_r  <= (state_next_s == ST_ACCUM);
            out_valid_r <= (state_next_s == ST_DONE);
            if ((state_r == ST_SCAN) && (scan_idx_r == LAST_IDX)) begin
                best_idx_r <= next_idx_s;
                best_sad_r <= next_sad_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign best_idx  = best_idx_r;
    assign best_sad  = best_sad_r;

endmodule

// File: tb/tb_frac_search_sad.sv
// Directed bench for frac_search_sad: table of uniform-pixel blocks with
// hand-computed winners, plus reset-abort and backpressure sequences.
module tb_frac_search_sad;

    localparam int NC = 9;
    localparam int RP = 8;
    localparam int PW = 8;

    typedef logic [NC-1:0][7:0] cands_t;
    typedef struct {
        logic [7:0]    ref_v;
        cands_t        cand_v;
        logic [NC-1:0] mask;
        logic [3:0]    exp_idx;
        logic [13:0]   exp_sad;
    } vec_t;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic [NC-1:0]       cand_mask = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [RP*PW-1:0]    ref_pix = '0;
    logic [NC*RP*PW-1:0] cand_pix = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [3:0]          best_idx;
    logic [13:0]         best_sad;

    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs [9];

    frac_search_sad dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cand_mask (cand_mask),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ref_pix   (ref_pix),
        .cand_pix  (cand_pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .best_idx  (best_idx),
        .best_sad  (best_sad)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic cands_t lin(input int base, input int step);
        cands_t c;
        for (int k = 0; k < NC; k++) c[k] = 8'(base + k * step);
        return c;
    endfunction

    task automatic set_vec(input int i, input int r, input cands_t c, input logic [NC-1:0] m,
                           input int idx, input int sad);
        vecs[i].ref_v   = 8'(r);
        vecs[i].cand_v  = c;
        vecs[i].mask    = m;
        vecs[i].exp_idx = 4'(idx);
        vecs[i].exp_sad = 14'(sad);
    endtask

    task automatic set_data(input logic [7:0] r, input cands_t c);
        for (int p = 0; p < RP; p++) ref_pix[p*PW +: PW] = r;
        for (int k = 0; k < NC; k++)
            for (int p = 0; p < RP; p++) cand_pix[(k*RP+p)*PW +: PW] = c[k];
    endtask

    // Starts a block and feeds n_rows beats; returns at the negedge after the last accept
    task automatic feed(input vec_t v, input string tag, input bit gaps, input bit stray,
                        input int n_rows);
        int  rows;
        int  cyc;
        bit  fire;
        @(negedge clk);
        start = 1'b1;
        cand_mask = v.mask;
        set_data(v.ref_v, v.cand_v);
        @(negedge clk);
        start = 1'b0;
        cand_mask = ~v.mask;
        rows = 0;
        cyc = 0;
        while (rows < n_rows && cyc < 100) begin
            in_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
            start = stray && (cyc == 3);
            fire = in_valid && in_ready;
            @(negedge clk);
            if (fire) rows++;
            cyc++;
        end
        start = 1'b0;
        in_valid = stray;
        chk({tag, " rows"}, rows, n_rows);
    endtask

    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, 10);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        feed(v, tag, 1'b0, 1'b0, 8);
        wait_result(tag);
        chk({tag, " idx"}, best_idx, v.exp_idx);
        chk({tag, " sad"}, best_sad, v.exp_sad);
        @(negedge clk);
        chk({tag, " valid drop"}, out_valid, 1'b0);
    endtask

    initial begin
        cands_t c;
        logic [3:0]  hold_idx;
        logic [13:0] hold_sad;
        bit          stable;

        set_vec(0, 100, lin(100, 1), 9'h1FF, 0, 0);
        c = lin(101, 0); c[3] = 8'd100; c[5] = 8'd100;
        set_vec(1, 100, c, 9'h1FF, 3, 0);
        c = lin(255, 0); c[8] = 8'd254;
        set_vec(2, 0, c, 9'h1FF, 8, 16256);
        set_vec(3, 0, lin(255, 0), 9'h1FF, 0, 16320);
        c = lin(51, 0); c[0] = 8'd50;
        set_vec(4, 50, c, 9'h1FE, 1, 64);
        set_vec(5, 50, c, 9'h000, 0, 16383);
        set_vec(6, 200, lin(190, 1), 9'h1FF, 8, 128);
        c = lin(30, 1); c[4] = 8'd9;
        set_vec(7, 10, c, 9'h1FF, 4, 64);
        set_vec(8, 10, c, 9'h1EF, 0, 1280);

        repeat (2) @(negedge clk);
        chk("reset in_ready", in_ready, 1'b0);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset best_idx", best_idx, 4'd0);
        chk("reset best_sad", best_sad, 14'd0);
        reset = 1'b1;

        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle in_ready", in_ready, 1'b0);
        in_valid = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of accumulation, then a clean block
        feed(vecs[2], "abort", 1'b0, 1'b0, 4);
        in_valid = 1'b1;
        reset = 1'b0;
        #1;
        chk("abort in_ready", in_ready, 1'b0);
        chk("abort out_valid", out_valid, 1'b0);
        chk("abort best_idx", best_idx, 4'd0);
        chk("abort best_sad", best_sad, 14'd0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        run_vec(vecs[6], "fresh");

        // Gapped input, stray starts, stalled output
        out_ready = 1'b0;
        feed(vecs[0], "bp", 1'b1, 1'b1, 8);
        wait_result("bp");
        in_valid = 1'b0;
        hold_idx = best_idx;
        hold_sad = best_sad;
        stable = 1'b1;
        for (int s = 0; s < 5; s++) begin
            start = (s == 2);
            @(negedge clk);
            if (!out_valid || best_idx !== hold_idx || best_sad !== hold_sad) stable = 1'b0;
        end
        start = 1'b0;
        chk("bp stall stable", stable, 1'b1);
        chk("bp idx", best_idx, 4'd0);
        chk("bp sad", best_sad, 14'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp valid drop", out_valid, 1'b0);
        @(negedge clk);
        chk("bp stray start ignored", in_ready, 1'b0);
        run_vec(vecs[7], "after bp");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
